step_phase_decoder: RTL and testbench

Receive-side monitor for the 4-phase half-step drive bus. It samples the phase pattern, filters glitches and decodes each pattern to one of 8 half-step indices. From each change of index it derives step direction, keeps a signed position count and flags illegal patterns or skipped steps. It sits beside the motor driver as a feedback/verification tap and feeds position to the display and control logic.

---
 rtl/step_pkg.sv | 44 ++++
 rtl/phase_sync_filter.sv | 66 ++++++
 rtl/step_phase_decoder.sv | 128 ++++++++++++
 tb/tb_step_phase_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared half-step phase patterns, tracker state and the pattern-to-index decoder
// used by both the drive side and the receive-side monitor.
package step_pkg;

    localparam logic [3:0] PH0    = 4'b1000;
    localparam logic [3:0] PH1    = 4'b1100;
    localparam logic [3:0] PH2    = 4'b0100;
    localparam logic [3:0] PH3    = 4'b0110;
    localparam logic [3:0] PH4    = 4'b0010;
    localparam logic [3:0] PH5    = 4'b0011;
    localparam logic [3:0] PH6    = 4'b0001;
    localparam logic [3:0] PH7    = 4'b1001;
    localparam logic [3:0] PH_OFF = 4'b0000;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } decode_t;

    // PH_OFF decodes as invalid here; callers screen it out before treating invalid as illegal.
    function automatic decode_t decode_phase(input logic [3:0] pattern);
        decode_t d;
        d.valid = 1'b1;
        d.idx   = 3'd0;
        case (pattern)
            PH0:     d.idx = 3'd0;
            PH1:     d.idx = 3'd1;
            PH2:     d.idx = 3'd2;
            PH3:     d.idx = 3'd3;
            PH4:     d.idx = 3'd4;
            PH5:     d.idx = 3'd5;
            PH6:     d.idx = 3'd6;
            PH7:     d.idx = 3'd7;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/phase_sync_filter.sv
// Two-flop synchronizer on the phase bus followed by a stability counter; emits a
// one-cycle accept strobe when a pattern has been seen STABLE_CYCLES times in a row.
module phase_sync_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] phase_in,
    output logic [3:0] pattern,
    output logic       accept
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [3:0]       sync1_reg;
    logic [3:0]       sync2_reg;
    logic [3:0]       last_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             accept_reg;
    logic             accept_next;
    logic             changed;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= phase_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    // A saturated counter still accepts again if the pattern just changed (STABLE_CYCLES = 1).
    always_comb begin
        changed     = (sync2_reg != last_reg);
        cnt_next    = cnt_reg;
        if (changed) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
        accept_next = (cnt_next == CNT_MAX) && (changed || (cnt_reg != CNT_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg   <= 4'b0000;
            cnt_reg    <= '0;
            accept_reg <= 1'b0;
        end else begin
            last_reg   <= sync2_reg;
            cnt_reg    <= cnt_next;
            accept_reg <= accept_next;
        end
    end

    assign pattern = last_reg;
    assign accept  = accept_reg;

endmodule

// File: rtl/step_phase_decoder.sv
// Receive-side half-step monitor: decodes filtered phase patterns into an index,
// tracks direction and signed position, and flags illegal patterns and skipped steps.
module step_phase_decoder
    import step_pkg::*;
#(
    parameter int POS_W         = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [3:0]       phase_in,
    output logic [2:0]       phase_idx,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step_valid,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);
    logic [3:0] flt_pattern;
    logic       flt_accept;

    phase_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .phase_in(phase_in),
        .pattern (flt_pattern),
        .accept  (flt_accept)
    );

    state_t           state_reg, state_next;
    logic [2:0]       phase_idx_reg, phase_idx_next;
    logic [POS_W-1:0] position_reg, position_next;
    logic             dir_reg, dir_next;
    logic             step_valid_reg, step_valid_next;
    logic             fault_reg, fault_next;
    logic [ERR_W-1:0] err_reg, err_next;
    decode_t          dec;
    logic [2:0]       delta;
    logic             err_event;

    always_comb begin
        state_next      = state_reg;
        phase_idx_next  = phase_idx_reg;
        position_next   = position_reg;
        dir_next        = dir_reg;
        step_valid_next = 1'b0;
        fault_next      = fault_reg;
        err_next        = err_reg;
        err_event       = 1'b0;
        dec             = decode_phase(flt_pattern);
        delta           = dec.idx - phase_idx_reg;

        if (flt_accept && (flt_pattern != PH_OFF)) begin
            if (!dec.valid) begin
                err_event  = 1'b1;
                state_next = IDLE;
            end else if (state_reg == IDLE) begin
                phase_idx_next = dec.idx;
                state_next     = TRACK;
            end else begin
                phase_idx_next = dec.idx;
                case (delta)
                    3'd0: ;
                    3'd1: begin
                        step_valid_next = 1'b1;
                        dir_next        = 1'b1;
                        position_next   = position_reg + POS_W'(1);
                    end
                    3'd7: begin
                        step_valid_next = 1'b1;
                        dir_next        = 1'b0;
                        position_next   = position_reg - POS_W'(1);
                    end
                    default: err_event = 1'b1;
                endcase
            end
        end

        if (err_event) begin
            fault_next = 1'b1;
            if (err_reg != {ERR_W{1'b1}}) begin
                err_next = err_reg + ERR_W'(1);
            end
        end

        // Clear overrides counters and the pulse, but the index reference and state still advance.
        if (clear) begin
            position_next   = '0;
            err_next        = '0;
            fault_next      = 1'b0;
            step_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            phase_idx_reg  <= 3'd0;
            position_reg   <= '0;
            dir_reg        <= 1'b0;
            step_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
            err_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            phase_idx_reg  <= phase_idx_next;
            position_reg   <= position_next;
            dir_reg        <= dir_next;
            step_valid_reg <= step_valid_next;
            fault_reg      <= fault_next;
            err_reg        <= err_next;
        end
    end

    assign phase_idx  = phase_idx_reg;
    assign position   = position_reg;
    assign dir        = dir_reg;
    assign step_valid = step_valid_reg;
    assign locked     = (state_reg == TRACK);
    assign fault      = fault_reg;
    assign err_count  = err_reg;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed self-checking bench for step_phase_decoder; a second narrow-position
// instance exercises the signed position wrap from max positive to min negative.
module tb_step_phase_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  phase_in = 4'b0000;
    logic [2:0]  phase_idx;
    logic [15:0] position;
    logic        dir;
    logic        step_valid;
    logic        locked;
    logic        fault;
    logic [7:0]  err_count;

    logic        clear_w = 1'b0;
    logic [3:0]  phase_in_w = 4'b0000;
    logic [2:0]  phase_idx_w;
    logic [3:0]  position_w;
    logic        dir_w;
    logic        step_valid_w;
    logic        locked_w;
    logic        fault_w;
    logic [2:0]  err_count_w;

    int n_cmp = 0;
    int n_fail = 0;
    int pulse_cnt = 0;
    int fwd_cnt = 0;
    int rev_cnt = 0;
    int base_p, base_f, base_r;

    always #5 clk = ~clk;

    step_phase_decoder #(.POS_W(16), .STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .phase_in  (phase_in),
        .phase_idx (phase_idx),
        .position  (position),
        .dir       (dir),
        .step_valid(step_valid),
        .locked    (locked),
        .fault     (fault),
        .err_count (err_count)
    );

    step_phase_decoder #(.POS_W(4), .STABLE_CYCLES(4), .ERR_W(3)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_w),
        .phase_in  (phase_in_w),
        .phase_idx (phase_idx_w),
        .position  (position_w),
        .dir       (dir_w),
        .step_valid(step_valid_w),
        .locked    (locked_w),
        .fault     (fault_w),
        .err_count (err_count_w)
    );

    always @(negedge clk) begin
        if (step_valid === 1'b1) begin
            pulse_cnt++;
            if (dir === 1'b1) fwd_cnt++;
            else rev_cnt++;
        end
    end

    task automatic apply(input logic [3:0] pat, input int hold);
        @(negedge clk);
        phase_in = pat;
        repeat (hold) @(negedge clk);
        $display("apply %b hold %0d: idx=%0d pos=%h dir=%0b locked=%0b fault=%0b err=%0d",
                 pat, hold, phase_idx, position, dir, locked, fault, err_count);
    endtask

    task automatic apply_w(input logic [3:0] pat);
        @(negedge clk);
        phase_in_w = pat;
        repeat (10) @(negedge clk);
        $display("apply_w %b: idx=%0d pos=%h locked=%0b", pat, phase_idx_w, position_w, locked_w);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (locked !== 1'b0)      begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_cmp++; if (position !== 16'h0)   begin n_fail++; $display("FAIL reset_position: got %h expected 0000", position); end
        n_cmp++; if (phase_idx !== 3'd0)   begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", phase_idx); end
        n_cmp++; if (step_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_step_valid: got %b expected 0", step_valid); end
        n_cmp++; if ({fault, err_count} !== 9'h0) begin n_fail++; $display("FAIL reset_errors: got fault=%b err=%h expected 0/00", fault, err_count); end
        reset = 1'b0;
        base_p = pulse_cnt;
        @(negedge clk);
        phase_in = 4'b1000;
        repeat (6) @(negedge clk);
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b expected 0 after 6 edges", locked); end
        @(negedge clk);
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_latency: got %b expected 1 after 7 edges", locked); end
        repeat (5) @(negedge clk);
        $display("reset/lock: idx=%0d pos=%h locked=%0b", phase_idx, position, locked);
        n_cmp++; if (phase_idx !== 3'd0)   begin n_fail++; $display("FAIL lock_idx: got %0d expected 0", phase_idx); end
        n_cmp++; if (position !== 16'h0)   begin n_fail++; $display("FAIL lock_position: got %h expected 0000", position); end
        n_cmp++; if (pulse_cnt !== base_p) begin n_fail++; $display("FAIL lock_no_step: got %0d pulses expected 0", pulse_cnt - base_p); end
    endtask

    task automatic test_forward;
        logic [3:0] seq [8];
        seq = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
        base_p = pulse_cnt; base_f = fwd_cnt;
        for (int i = 0; i < 8; i++) apply(seq[i], 10);
        n_cmp++; if (pulse_cnt - base_p !== 8) begin n_fail++; $display("FAIL fwd_pulses: got %0d expected 8", pulse_cnt - base_p); end
        n_cmp++; if (fwd_cnt - base_f !== 8)   begin n_fail++; $display("FAIL fwd_dir: got %0d forward pulses expected 8", fwd_cnt - base_f); end
        n_cmp++; if (position !== 16'd8)       begin n_fail++; $display("FAIL fwd_position: got %h expected 0008", position); end
        n_cmp++; if (phase_idx !== 3'd0)       begin n_fail++; $display("FAIL fwd_idx: got %0d expected 0", phase_idx); end
    endtask

    task automatic test_reverse;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        $display("clear: pos=%h", position);
        n_cmp++; if (position !== 16'h0) begin n_fail++; $display("FAIL clear_position: got %h expected 0000", position); end
        base_p = pulse_cnt; base_r = rev_cnt;
        apply(4'b1001, 10);
        apply(4'b0001, 10);
        n_cmp++; if (rev_cnt - base_r !== 2)   begin n_fail++; $display("FAIL rev_dir: got %0d reverse pulses expected 2", rev_cnt - base_r); end
        n_cmp++; if (pulse_cnt - base_p !== 2) begin n_fail++; $display("FAIL rev_pulses: got %0d expected 2", pulse_cnt - base_p); end
        n_cmp++; if (position !== 16'hFFFE)    begin n_fail++; $display("FAIL rev_position: got %h expected fffe", position); end
        n_cmp++; if (phase_idx !== 3'd6)       begin n_fail++; $display("FAIL rev_idx: got %0d expected 6", phase_idx); end
        apply(4'b0000, 10);
        n_cmp++; if ({fault, err_count} !== 9'h0) begin n_fail++; $display("FAIL off_no_error: got fault=%b err=%h expected 0/00", fault, err_count); end
        n_cmp++; if (phase_idx !== 3'd6 || position !== 16'hFFFE || locked !== 1'b1) begin
            n_fail++; $display("FAIL off_hold: got idx=%0d pos=%h locked=%b expected 6/fffe/1", phase_idx, position, locked);
        end
    endtask

    task automatic test_glitch_skip;
        apply(4'b1001, 10);
        apply(4'b1000, 10);
        apply(4'b1100, 10);
        apply(4'b0100, 10);
        n_cmp++; if (position !== 16'd2) begin n_fail++; $display("FAIL pre_glitch_position: got %h expected 0002", position); end
        base_p = pulse_cnt;
        apply(4'b0110, 2);
        apply(4'b0100, 10);
        n_cmp++; if (pulse_cnt !== base_p) begin n_fail++; $display("FAIL glitch_no_step: got %0d pulses expected 0", pulse_cnt - base_p); end
        n_cmp++; if (position !== 16'd2 || phase_idx !== 3'd2) begin
            n_fail++; $display("FAIL glitch_hold: got pos=%h idx=%0d expected 0002/2", position, phase_idx);
        end
        apply(4'b0010, 10);
        n_cmp++; if (fault !== 1'b1 || err_count !== 8'd1) begin
            n_fail++; $display("FAIL skip_error: got fault=%b err=%0d expected 1/1", fault, err_count);
        end
        n_cmp++; if (phase_idx !== 3'd4 || position !== 16'd2 || locked !== 1'b1 || pulse_cnt !== base_p) begin
            n_fail++; $display("FAIL skip_state: got idx=%0d pos=%h locked=%b pulses=%0d expected 4/0002/1/0",
                               phase_idx, position, locked, pulse_cnt - base_p);
        end
    endtask

    task automatic test_illegal_clear;
        apply(4'b1111, 10);
        n_cmp++; if (locked !== 1'b0 || fault !== 1'b1 || err_count !== 8'd2 || phase_idx !== 3'd4) begin
            n_fail++; $display("FAIL illegal: got locked=%b fault=%b err=%0d idx=%0d expected 0/1/2/4",
                               locked, fault, err_count, phase_idx);
        end
        base_p = pulse_cnt;
        apply(4'b1100, 10);
        n_cmp++; if (locked !== 1'b1 || phase_idx !== 3'd1 || pulse_cnt !== base_p || position !== 16'd2) begin
            n_fail++; $display("FAIL relock: got locked=%b idx=%0d pulses=%0d pos=%h expected 1/1/0/0002",
                               locked, phase_idx, pulse_cnt - base_p, position);
        end
        @(negedge clk);
        phase_in = 4'b0100;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        $display("clear+step: idx=%0d pos=%h step_valid=%0b err=%0d", phase_idx, position, step_valid, err_count);
        n_cmp++; if (step_valid !== 1'b0 || pulse_cnt !== base_p) begin
            n_fail++; $display("FAIL clear_step_pulse: got step_valid=%b pulses=%0d expected 0/0", step_valid, pulse_cnt - base_p);
        end
        n_cmp++; if (position !== 16'h0 || err_count !== 8'h0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL clear_wins: got pos=%h err=%h fault=%b expected 0000/00/0", position, err_count, fault);
        end
        n_cmp++; if (phase_idx !== 3'd2 || locked !== 1'b1) begin
            n_fail++; $display("FAIL clear_keeps_ref: got idx=%0d locked=%b expected 2/1", phase_idx, locked);
        end
    endtask

    task automatic test_position_wrap;
        apply_w(4'b1000);
        apply_w(4'b1100);
        apply_w(4'b0100);
        apply_w(4'b0110);
        apply_w(4'b0010);
        apply_w(4'b0011);
        apply_w(4'b0001);
        apply_w(4'b1001);
        n_cmp++; if (position_w !== 4'h7) begin n_fail++; $display("FAIL wrap_max: got %h expected 7", position_w); end
        apply_w(4'b1000);
        n_cmp++; if (position_w !== 4'h8 || dir_w !== 1'b1 || fault_w !== 1'b0) begin
            n_fail++; $display("FAIL wrap_min: got pos=%h dir=%b fault=%b expected 8/1/0", position_w, dir_w, fault_w);
        end
    endtask

    task automatic test_err_saturate;
        for (int i = 0; i < 256; i++) apply((i % 2 == 0) ? 4'b1111 : 4'b1010, 6);
        n_cmp++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL err_saturate: got %h expected ff", err_count); end
        n_cmp++; if (fault !== 1'b1 || locked !== 1'b0) begin
            n_fail++; $display("FAIL err_state: got fault=%b locked=%b expected 1/0", fault, locked);
        end
    endtask

    task automatic test_reset_mid;
        apply(4'b1000, 10);
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL pre_reset_lock: got %b expected 1", locked); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("async reset: locked=%0b err=%h fault=%0b", locked, err_count, fault);
        n_cmp++; if (locked !== 1'b0 || err_count !== 8'h0 || fault !== 1'b0 || position !== 16'h0) begin
            n_fail++; $display("FAIL reset_async: got locked=%b err=%h fault=%b pos=%h expected 0/00/0/0000",
                               locked, err_count, fault, position);
        end
        @(negedge clk);
        reset = 1'b0;
        base_p = pulse_cnt;
        apply(4'b1100, 10);
        n_cmp++; if (locked !== 1'b1 || phase_idx !== 3'd1 || pulse_cnt !== base_p) begin
            n_fail++; $display("FAIL post_reset_first: got locked=%b idx=%0d pulses=%0d expected 1/1/0",
                               locked, phase_idx, pulse_cnt - base_p);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch_skip();
        test_illegal_clear();
        test_position_wrap();
        test_err_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
